ms_section_collector: RTL

- Parametrised master/slave section block: a multi-channel successor to the single-slave, two-section skeleton.
- Collects BATCH samples from NUM_CH slave input channels (each with a sync flag), using round-robin arbitration, then reduces them by sum or max.
- Presents the batch result on a master port with a valid/ready handshake.
- Sits between slave producers and a downstream master consumer in the property-generation test designs.

---
 rtl/ms_section_collector.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ms_section_collector.sv
// Round-robin batch collector: takes BATCH samples from NUM_CH held-data slave
// channels, reduces them by sum or unsigned max, and offers the result on a master port.
module ms_section_collector #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int BATCH  = 4,
    parameter int MODE   = 0,
    localparam int OW = (BATCH > 1) ? WIDTH + $clog2(BATCH) : WIDTH + 1,
    localparam int CW = $clog2(BATCH + 1),
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] s_in,
    input  logic [NUM_CH-1:0]       s_in_sync,
    output logic [NUM_CH-1:0]       s_ack,
    output logic [OW-1:0]           m_out,
    output logic                    m_out_valid,
    input  logic                    m_out_ready,
    output logic                    section_o,
    output logic [CW-1:0]           cnt_o
);

    typedef enum logic {
        SEC_COLLECT = 1'b0,
        SEC_EMIT    = 1'b1
    } section_t;

    section_t          section_q, section_d;
    logic [OW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [OW-1:0]     m_out_q, m_out_d;
    logic              m_out_valid_q, m_out_valid_d;

    logic              grant_found;
    logic [PW-1:0]     grant_idx;
    logic [NUM_CH-1:0] grant_vec;
    logic [WIDTH-1:0]  sample;
    logic [OW-1:0]     sample_ext;
    logic [OW-1:0]     reduced;
    int                idx;

    // Handshakes: slave side, a sample transfers in the cycle s_in_sync[i] && s_ack[i]
    // (the producer holds data until then); master side, a result transfers in the
    // cycle m_out_valid && m_out_ready, and m_out is frozen while valid waits for ready.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_CH;
            if (!grant_found && s_in_sync[idx]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(idx);
            end
        end
        if (section_q != SEC_COLLECT) begin
            grant_found = 1'b0;
        end
        grant_vec = '0;
        if (grant_found) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    assign sample     = s_in[int'(grant_idx)*WIDTH +: WIDTH];
    assign sample_ext = {{(OW-WIDTH){1'b0}}, sample};

    // The first sample of a batch loads directly so max never compares against stale data.
    always_comb begin
        if (MODE == 0) begin
            reduced = acc_q + sample_ext;
        end else if (cnt_q == '0 || sample_ext > acc_q) begin
            reduced = sample_ext;
        end else begin
            reduced = acc_q;
        end
    end

    always_comb begin
        section_d     = section_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        rr_ptr_d      = rr_ptr_q;
        m_out_d       = m_out_q;
        m_out_valid_d = m_out_valid_q;
        case (section_q)
            SEC_COLLECT: begin
                if (grant_found) begin
                    if (int'(grant_idx) == NUM_CH - 1) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = grant_idx + 1'b1;
                    end
                    cnt_d = cnt_q + 1'b1;
                    acc_d = reduced;
                    if (cnt_q == CW'(BATCH - 1)) begin
                        m_out_d       = reduced;
                        m_out_valid_d = 1'b1;
                        section_d     = SEC_EMIT;
                    end
                end
            end
            SEC_EMIT: begin
                if (m_out_valid_q && m_out_ready) begin
                    m_out_valid_d = 1'b0;
                    acc_d         = '0;
                    cnt_d         = '0;
                    section_d     = SEC_COLLECT;
                end
            end
            default: begin
                section_d = SEC_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            section_q     <= SEC_COLLECT;
            acc_q         <= '0;
            cnt_q         <= '0;
            rr_ptr_q      <= '0;
            m_out_q       <= '0;
            m_out_valid_q <= 1'b0;
        end else begin
            section_q     <= section_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            m_out_q       <= m_out_d;
            m_out_valid_q <= m_out_valid_d;
        end
    end

    // The grant is combinational from sync, so it is gated to keep s_ack quiet during reset.
    assign s_ack       = rst ? '0 : grant_vec;
    assign m_out       = m_out_q;
    assign m_out_valid = m_out_valid_q;
    assign section_o   = section_q;
    assign cnt_o       = cnt_q;

endmodule
